// File: rtl/regfile_fwd_pkg.sv
// Shared constants for the bitty core register file and its forwarding mux.
// Names mirror the core-wide definitions so the block drops into the existing slice.
package regfile_fwd_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic        ReadEnable  = 1'b1;
  localparam int          RegBus      = 32;
  localparam int          RegAddrBus  = 5;
  localparam int          RegNum      = 32;
  localparam int          RegNumLog2  = 5;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr  = 5'd0;

endpackage

// File: rtl/regfile_fwd_sel.sv
// Per-port read mux: zero rules, EX > MEM > WB bypass, then array data.
// Also produces this port's load-use hazard term.
module regfile_fwd_sel
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegAddrBus
) (
  input  logic              rst,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] arr_data_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ex_wreg_i,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_load_i,
  input  logic              mem_wreg_i,
  input  logic [ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              hazard_o
);

  logic rd_active;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign rd_active = (rst != RstEnable) && (re_i == ReadEnable) && (raddr_i != '0);
  assign ex_hit    = ex_wreg_i  && (ex_wd_i  == raddr_i);
  assign mem_hit   = mem_wreg_i && (mem_wd_i == raddr_i);
  assign wb_hit    = (we_i == WriteEnable) && (waddr_i == raddr_i);

  // Youngest producer first; a load in EX has no data yet, so it reads as zero
  // while the hazard output holds decode.
  always_comb begin
    rdata_o = '0;
    if (rd_active) begin
      if (ex_hit) begin
        rdata_o = ex_load_i ? '0 : ex_wdata_i;
      end else if (mem_hit) begin
        rdata_o = mem_wdata_i;
      end else if (wb_hit) begin
        rdata_o = wdata_i;
      end else begin
        rdata_o = arr_data_i;
      end
    end
  end

  assign hazard_o = rd_active && ex_load_i && ex_hit;

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 integer register file with EX/MEM/WB forwarding and load-use stall request.
// x0 has no storage; the array holds x1..x(NUM_REGS-1).
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = RegBus,
  parameter int ADDR_W   = RegAddrBus,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              ex_wreg_i,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_load_i,
  input  logic              mem_wreg_i,
  input  logic [ADDR_W-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              stallreq_o
);

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
  logic [DATA_W-1:0] arr1_data;
  logic [DATA_W-1:0] arr2_data;
  logic              hazard1;
  logic              hazard2;

  // Reset wins over a same-cycle commit, so that write is lost.
  always_comb begin
    regs_d = regs_q;
    if (rst == RstEnable) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end else if ((we_i == WriteEnable) && (waddr_i != '0)) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (waddr_i == ADDR_W'(i)) begin
          regs_d[i] = wdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    arr1_data = '0;
    arr2_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (raddr1_i == ADDR_W'(i)) begin
        arr1_data = regs_q[i];
      end
      if (raddr2_i == ADDR_W'(i)) begin
        arr2_data = regs_q[i];
      end
    end
  end

  regfile_fwd_sel #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sel1 (
    .rst         (rst),
    .re_i        (re1_i),
    .raddr_i     (raddr1_i),
    .arr_data_i  (arr1_data),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .ex_wreg_i   (ex_wreg_i),
    .ex_wd_i     (ex_wd_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_load_i   (ex_load_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wd_i    (mem_wd_i),
    .mem_wdata_i (mem_wdata_i),
    .rdata_o     (rdata1_o),
    .hazard_o    (hazard1)
  );

  regfile_fwd_sel #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sel2 (
    .rst         (rst),
    .re_i        (re2_i),
    .raddr_i     (raddr2_i),
    .arr_data_i  (arr2_data),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .ex_wreg_i   (ex_wreg_i),
    .ex_wd_i     (ex_wd_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_load_i   (ex_load_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wd_i    (mem_wd_i),
    .mem_wdata_i (mem_wdata_i),
    .rdata_o     (rdata2_o),
    .hazard_o    (hazard2)
  );

  assign stallreq_o = hazard1 | hazard2;

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: a reference array plus read/stall rules checked
// every negedge, alongside hand-computed literal expectations.
module tb_regfile_fwd;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic        ex_wreg_i;
  logic [4:0]  ex_wd_i;
  logic [31:0] ex_wdata_i;
  logic        ex_load_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_wd_i;
  logic [31:0] mem_wdata_i;
  logic        stallreq_o;

  int checks;
  int errors;
  logic [31:0] model [32];

  regfile_fwd dut (
    .clk         (clk),
    .rst         (rst),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .re1_i       (re1_i),
    .raddr1_i    (raddr1_i),
    .rdata1_o    (rdata1_o),
    .re2_i       (re2_i),
    .raddr2_i    (raddr2_i),
    .rdata2_o    (rdata2_o),
    .ex_wreg_i   (ex_wreg_i),
    .ex_wd_i     (ex_wd_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_load_i   (ex_load_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wd_i    (mem_wd_i),
    .mem_wdata_i (mem_wdata_i),
    .stallreq_o  (stallreq_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: architectural registers as plain words.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we_i && waddr_i != 5'd0) begin
      model[waddr_i] = wdata_i;
    end
  end

  function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (ex_wreg_i && ex_wd_i == a) return ex_load_i ? 32'h0 : ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a) return mem_wdata_i;
    if (we_i && waddr_i == a) return wdata_i;
    return model[a];
  endfunction

  function automatic logic exp_stall();
    if (rst || !ex_load_i || !ex_wreg_i || ex_wd_i == 5'd0) return 1'b0;
    return (re1_i && raddr1_i == ex_wd_i) || (re2_i && raddr2_i == ex_wd_i);
  endfunction

  always @(negedge clk) begin
    chk("model_rdata1", rdata1_o, exp_read(re1_i, raddr1_i));
    chk("model_rdata2", rdata2_o, exp_read(re2_i, raddr2_i));
    chk("model_stall", {31'h0, stallreq_o}, {31'h0, exp_stall()});
  end

  task automatic idle();
    we_i = 0; waddr_i = 0; wdata_i = 0;
    re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'hFFFF_FFFF;
    idle();
    rst = 1;
    we_i = 1; waddr_i = 5'd4; wdata_i = 32'h1111_1111; re1_i = 1; raddr1_i = 5'd4;
    #2;
    chk("rst_rdata1", rdata1_o, 32'h0);
    repeat (2) next_cycle();
    rst = 0;
    idle();

    // Reset state on both ports
    for (int i = 1; i < 32; i++) begin
      re1_i = 1; raddr1_i = 5'(i); re2_i = 1; raddr2_i = 5'(i);
      #2;
      chk("reset_rd1", rdata1_o, 32'h0);
      chk("reset_rd2", rdata2_o, 32'h0);
      chk("reset_stall", {31'h0, stallreq_o}, 32'h0);
      next_cycle();
    end
    idle();

    // Write/read and x0 discard
    we_i = 1; waddr_i = 5'd5; wdata_i = 32'hDEAD_BEEF;
    next_cycle();
    idle(); re1_i = 1; raddr1_i = 5'd5;
    #2; chk("wr_rd_x5", rdata1_o, 32'hDEAD_BEEF);
    next_cycle();
    idle(); we_i = 1; waddr_i = 5'd0; wdata_i = 32'h1234; re1_i = 1; raddr1_i = 5'd0;
    #2; chk("x0_bypass", rdata1_o, 32'h0);
    next_cycle();
    idle(); re1_i = 1; raddr1_i = 5'd0;
    #2; chk("x0_read", rdata1_o, 32'h0);
    next_cycle();

    // Bypass priority on x7
    idle(); we_i = 1; waddr_i = 5'd7; wdata_i = 32'h1;
    next_cycle();
    idle();
    we_i = 1; waddr_i = 5'd7; wdata_i = 32'h2;
    mem_wreg_i = 1; mem_wd_i = 5'd7; mem_wdata_i = 32'h3;
    ex_wreg_i = 1; ex_wd_i = 5'd7; ex_wdata_i = 32'h4;
    re1_i = 1; raddr1_i = 5'd7; re2_i = 1; raddr2_i = 5'd7;
    #1; chk("fwd_ex", rdata1_o, 32'h4);
    ex_wreg_i = 0;
    #1; chk("fwd_mem", rdata1_o, 32'h3);
    mem_wreg_i = 0;
    #1; chk("fwd_wb", rdata2_o, 32'h2);
    we_i = 0;
    #1; chk("fwd_array", rdata1_o, 32'h1);
    next_cycle();

    // Load-use stall, then forward from MEM
    idle();
    ex_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd9; ex_wdata_i = 32'hBAD0_BAD0;
    re2_i = 1; raddr2_i = 5'd9;
    #2;
    chk("lu_stall", {31'h0, stallreq_o}, 32'h1);
    chk("lu_rd2_zero", rdata2_o, 32'h0);
    next_cycle();
    idle(); mem_wreg_i = 1; mem_wd_i = 5'd9; mem_wdata_i = 32'hCAFE;
    re2_i = 1; raddr2_i = 5'd9;
    #2;
    chk("lu_nostall", {31'h0, stallreq_o}, 32'h0);
    chk("lu_mem_fwd", rdata2_o, 32'hCAFE);
    next_cycle();
    idle(); ex_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd12; re1_i = 1; raddr1_i = 5'd12;
    #2; chk("lu_stall_p1", {31'h0, stallreq_o}, 32'h1);
    re1_i = 0;
    #1; chk("lu_re_off", {31'h0, stallreq_o}, 32'h0);
    next_cycle();

    // x0 and read enables
    idle(); ex_load_i = 1; ex_wreg_i = 1; ex_wd_i = 5'd0; ex_wdata_i = 32'h77;
    re1_i = 1; raddr1_i = 5'd0;
    #2;
    chk("x0_nostall", {31'h0, stallreq_o}, 32'h0);
    chk("x0_nofwd", rdata1_o, 32'h0);
    next_cycle();
    idle(); re1_i = 0; raddr1_i = 5'd5; re2_i = 1; raddr2_i = 5'd5;
    #2;
    chk("re1_off", rdata1_o, 32'h0);
    chk("re2_on", rdata2_o, 32'hDEAD_BEEF);
    next_cycle();

    // Reset mid-write
    idle(); we_i = 1; waddr_i = 5'd3; wdata_i = 32'h55; rst = 1;
    re1_i = 1; raddr1_i = 5'd3;
    #2; chk("rst_mid_rd", rdata1_o, 32'h0);
    next_cycle();
    rst = 0;
    idle(); re1_i = 1; raddr1_i = 5'd3; re2_i = 1; raddr2_i = 5'd5;
    #2;
    chk("rst_lost_x3", rdata1_o, 32'h0);
    chk("rst_clr_x5", rdata2_o, 32'h0);
    next_cycle();
    idle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- 32x32 integer register file for the bitty core. It is the consumer end of the execute-stage result interface (wd/wreg/wdata).
- Accepts write-back commits into the architectural array.
- Serves the decode stage's two source reads, with forwarding of in-flight results from the EX and MEM stages.
- Raises a load-use stall request when a source depends on a load still in EX.
- Sits between id (read side) and the ex/mem/wb result buses (write side).

Parameters:
- DATA_W, 32, register width (matches RegBus).
- ADDR_W, 5, register address width (matches RegAddrBus).
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- we_i  in  1  write-back write enable.
- waddr_i  in  ADDR_W  write-back destination register.
- wdata_i  in  DATA_W  write-back data.
- re1_i  in  1  read enable, port 1.
- raddr1_i  in  ADDR_W  read address, port 1.
- rdata1_o  out  DATA_W  read data, port 1.
- re2_i  in  1  read enable, port 2.
- raddr2_i  in  ADDR_W  read address, port 2.
- rdata2_o  out  DATA_W  read data, port 2.
- ex_wreg_i  in  1  EX stage will write a register.
- ex_wd_i  in  ADDR_W  EX destination register.
- ex_wdata_i  in  DATA_W  EX result.
- ex_load_i  in  1  EX instruction is a load; ex_wdata_i is not yet valid.
- mem_wreg_i  in  1  MEM stage will write a register.
- mem_wd_i  in  ADDR_W  MEM destination register.
- mem_wdata_i  in  DATA_W  MEM result.
- stallreq_o  out  1  load-use hazard; decode must hold for one cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All NUM_REGS-1 storage words clear to 0.
  - While rst=1: rdata1_o=0, rdata2_o=0, stallreq_o=0, and any write is ignored.
- Write:
  - At the rising edge, when rst=0, we_i=1 and waddr_i!=0, array[waddr_i] takes wdata_i.
  - Writes to x0 are discarded.
  - Write latency is 1 cycle.
- Read ports are combinational (0-cycle latency) and identical for port n=1,2. Priority order, first match wins:
  1. rst=1 -> 0.
  2. re_n=0 -> 0.
  3. raddr_n=0 -> 0. No forwarding to x0, even if a stage targets x0.
  4. ex_wreg_i=1 and ex_wd_i==raddr_n -> ex_wdata_i (0 if ex_load_i=1).
  5. mem_wreg_i=1 and mem_wd_i==raddr_n -> mem_wdata_i.
  6. we_i=1 and waddr_i==raddr_n -> wdata_i (write-first bypass of the same-cycle commit).
  7. Otherwise -> array[raddr_n].
- Youngest producer wins: with EX, MEM and WB all targeting the same register, EX data is returned.
- stallreq_o = ex_load_i & ex_wreg_i & (ex_wd_i!=0) & ((re1_i & raddr1_i==ex_wd_i) | (re2_i & raddr2_i==ex_wd_i)).
- stallreq_o is purely combinational. It deasserts once the load advances to MEM, where it is forwarded by rule 5.
- Forward inputs are sampled only combinationally; the block holds no pipeline state besides the array.
- The array contents hold through stalls; there is no stall or flush input.
- Reset mid-operation: a write presented in the same cycle rst=1 is lost. The first cycle after rst falls reads all zeros.

Decomposition:
- Shared constants belong in bitty_defs: RstEnable, ZeroWord, RegBus, RegAddrBus, WriteEnable, ReadEnable, RegNum, RegNumLog2, NOPRegAddr.
- One sub-module is natural: regfile_fwd_sel. It implements the per-port priority mux (rules 1-7 plus that port's hazard term) and is instantiated twice.
- Array storage and the write logic stay in regfile_fwd.

Test Plan:
- Reset: pulse rst for 2 cycles, then read x1..x31 on both ports -> all return 0; stallreq_o=0.
- Write/read: write x5=0xDEADBEEF, next cycle read raddr1=5 -> 0xDEADBEEF. Write x0=0x1234, read x0 -> 0.
- Bypass priority: array x7=0x1, wb writes x7=0x2, mem_wd=7/0x3, ex_wd=7/0x4 -> rdata=0x4. Drop EX -> 0x3. Drop MEM -> 0x2. Drop WB -> 0x1.
- Load-use: ex_load=1, ex_wreg=1, ex_wd=9, re2=1, raddr2=9 -> stallreq_o=1. Next cycle, same load on mem_wd=9/0xCAFE -> stallreq_o=0, rdata2=0xCAFE.
- x0 and read enables:
  - ex_wd=0, ex_load=1, raddr1=0, re1=1 -> stallreq_o=0, rdata1=0.
  - re1=0 with raddr1 matching a populated register -> rdata1=0.
- Reset mid-write: we_i=1, x3=0x55 in the same cycle rst=1 -> after reset, read x3 returns 0.
